// File: rtl/seg_ring_pkg.sv
// Shared types, segment codes and ring-length helper for the seg_ring_chaser display animator.
package seg_ring_pkg;

  typedef logic [7:0] sseg_t;

  // Active-low {dp,g,f,e,d,c,b,a}
  localparam sseg_t SEG_BLANK    = 8'hFF;
  localparam sseg_t SEG_UPPER_SQ = 8'h9C;
  localparam sseg_t SEG_LOWER_SQ = 8'hA3;
  localparam sseg_t SEG_A        = 8'hFE;
  localparam sseg_t SEG_B        = 8'hFD;
  localparam sseg_t SEG_C        = 8'hFB;
  localparam sseg_t SEG_D        = 8'hF7;
  localparam sseg_t SEG_E        = 8'hEF;
  localparam sseg_t SEG_F        = 8'hDF;

  typedef enum logic {MODE_SQUARE = 1'b0, MODE_SNAKE = 1'b1} mode_e;

  function automatic int ring_len(input mode_e m, input int n);
    return (m == MODE_SNAKE) ? 2*n + 4 : 2*n;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-DIV prescaler; tick is high on the terminal count while en is set.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: DIV must be >= 1");
  end

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/seg_ring_chaser.sv
// Animates a square or perimeter snake around an N-digit multiplexed seven-segment display.
module seg_ring_chaser
  import seg_ring_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STEP_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  dir,
  input  logic                                  mode,
  output logic [NUM_DIGITS-1:0]                 an,
  output logic [7:0]                            sseg,
  output logic [$clog2(2*NUM_DIGITS+4)-1:0]     pos
);

  localparam int PW = $clog2(2*NUM_DIGITS + 4);
  localparam int DW = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2) begin : g_bad_n
    $error("seg_ring_chaser: NUM_DIGITS must be >= 2");
  end
  if (STEP_DIV < 1) begin : g_bad_step
    $error("seg_ring_chaser: STEP_DIV must be >= 1");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("seg_ring_chaser: SCAN_DIV must be >= 1");
  end

  mode_e         mode_q;
  logic          mode_chg;
  logic          step_tick;
  logic          scan_tick;
  logic [DW-1:0] digit;
  logic [PW-1:0] pos_nxt;
  int            len;
  int            tgt;
  sseg_t         pat;

  assign mode_chg = (mode_e'(mode) != mode_q);

  // A mode change restarts the step prescaler alongside the position.
  tick_gen #(.DIV(STEP_DIV)) u_step (
    .clk (clk),
    .rst (rst || mode_chg),
    .en  (en),
    .tick(step_tick)
  );

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .tick(scan_tick)
  );

  function automatic void map_pos(input mode_e m, input int p, output int d, output sseg_t s);
    d = 0;
    s = SEG_BLANK;
    if (m == MODE_SQUARE) begin
      if (p < NUM_DIGITS) begin d = NUM_DIGITS - 1 - p; s = SEG_UPPER_SQ; end
      else                begin d = p - NUM_DIGITS;     s = SEG_LOWER_SQ; end
    end else if (p < NUM_DIGITS) begin
      d = NUM_DIGITS - 1 - p; s = SEG_A;
    end else if (p == NUM_DIGITS) begin
      d = 0; s = SEG_B;
    end else if (p == NUM_DIGITS + 1) begin
      d = 0; s = SEG_C;
    end else if (p <= 2*NUM_DIGITS + 1) begin
      d = p - (NUM_DIGITS + 2); s = SEG_D;
    end else if (p == 2*NUM_DIGITS + 2) begin
      d = NUM_DIGITS - 1; s = SEG_E;
    end else begin
      d = NUM_DIGITS - 1; s = SEG_F;
    end
  endfunction

  always_comb begin
    map_pos(mode_q, int'(pos), tgt, pat);
  end

  always_comb begin
    len     = ring_len(mode_q, NUM_DIGITS);
    pos_nxt = pos;
    if (mode_chg)
      pos_nxt = '0;
    else if (step_tick) begin
      if (dir)
        pos_nxt = (int'(pos) == len - 1) ? '0 : pos + 1'b1;
      else
        pos_nxt = (pos == '0) ? PW'(len - 1) : pos - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      digit  <= '0;
      mode_q <= mode_e'(mode);
      an     <= '1;
      sseg   <= SEG_BLANK;
    end else begin
      pos    <= pos_nxt;
      mode_q <= mode_e'(mode);
      if (scan_tick)
        digit <= (int'(digit) == NUM_DIGITS - 1) ? '0 : digit + 1'b1;
      an     <= ~(NUM_DIGITS'(1) << digit);
      // dp is forced off regardless of the pattern table
      sseg   <= (int'(digit) == tgt) ? {1'b1, pat[6:0]} : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_ring_chaser.sv
// Scoreboard bench: a perimeter-walk model predicts an/sseg/pos every cycle; a negedge monitor compares.
module tb_seg_ring_chaser;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int CD = 1;
  localparam int PW = $clog2(2*N + 4);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          dir = 1'b1;
  logic          mode = 1'b0;
  logic [N-1:0]  an;
  logic [7:0]    sseg;
  logic [PW-1:0] pos;

  seg_ring_chaser #(.NUM_DIGITS(N), .STEP_DIV(SD), .SCAN_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .dir (dir),
    .mode(mode),
    .an  (an),
    .sseg(sseg),
    .pos (pos)
  );

  always #2 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  an;
    logic [7:0]    sseg;
    logic [PW-1:0] pos;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Ring tables: entry k = (digit, pattern) lit at position k, walked clockwise.
  int         sq_dig[$];
  logic [7:0] sq_pat[$];
  int         sn_dig[$];
  logic [7:0] sn_pat[$];

  int   m_pos = 0, m_pre = 0, m_scan = 0, m_dig = 0;
  logic m_mode = 1'b0;

  task automatic build_tables();
    for (int i = 0; i < N; i++) begin sq_dig.push_back(N-1-i); sq_pat.push_back(8'h9C); end
    for (int i = 0; i < N; i++) begin sq_dig.push_back(i);     sq_pat.push_back(8'hA3); end
    // top edge left->right, right edge down, bottom edge right->left, left edge up
    for (int i = 0; i < N; i++) begin sn_dig.push_back(N-1-i); sn_pat.push_back(8'hFE); end
    sn_dig.push_back(0);   sn_pat.push_back(8'hFD);
    sn_dig.push_back(0);   sn_pat.push_back(8'hFB);
    for (int i = 0; i < N; i++) begin sn_dig.push_back(i);     sn_pat.push_back(8'hF7); end
    sn_dig.push_back(N-1); sn_pat.push_back(8'hEF);
    sn_dig.push_back(N-1); sn_pat.push_back(8'hDF);
  endtask

  always @(posedge clk) begin : model
    exp_t e;
    int   len, tgt;
    logic [7:0] pt;
    if (rst) begin
      m_pos = 0; m_pre = 0; m_scan = 0; m_dig = 0; m_mode = mode;
      e.an = '1; e.sseg = 8'hFF;
    end else begin
      e.an = ~(N'(1) << m_dig);
      tgt  = m_mode ? sn_dig[m_pos] : sq_dig[m_pos];
      pt   = m_mode ? sn_pat[m_pos] : sq_pat[m_pos];
      e.sseg = (tgt == m_dig) ? pt : 8'hFF;
      if (m_scan == CD - 1) begin m_scan = 0; m_dig = (m_dig + 1) % N; end
      else m_scan++;
      len = m_mode ? sn_dig.size() : sq_dig.size();
      if (mode != m_mode) begin
        m_mode = mode; m_pos = 0; m_pre = 0;
      end else if (en) begin
        if (m_pre == SD - 1) begin
          m_pre = 0;
          m_pos = dir ? (m_pos + 1) % len : (m_pos + len - 1) % len;
        end else m_pre++;
      end
    end
    e.pos = PW'(m_pos);
    sb.push_back(e);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("an",   16'(an),   16'(e.an));
      chk("sseg", 16'(sseg), 16'(e.sseg));
      chk("pos",  16'(pos),  16'(e.pos));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (m_pos != p && k < 200) begin cyc(1); k++; end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL wait_pos timeout: got %0d expected %0d", m_pos, p);
    end
  endtask

  task automatic wait_pre(input int v);
    int k = 0;
    while (m_pre != v && k < 200) begin cyc(1); k++; end
    if (k >= 200) begin
      checks++; errors++;
      $display("FAIL wait_pre timeout: got %0d expected %0d", m_pre, v);
    end
  endtask

  initial begin
    build_tables();
    rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    // clockwise square round trip, then ccw wrap from 0
    en = 1'b1;
    wait_pos(7);
    wait_pos(0);
    dir = 1'b0;
    wait_pos(7);
    dir = 1'b1;
    wait_pos(2);
    // freeze mid-prescale
    cyc(1);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    wait_pos(5);
    mode = 1'b1;
    cyc(1);
    wait_pos(11);
    wait_pos(0);
    cyc(3);
    // mode change landing on a tick cycle
    wait_pre(SD - 1);
    mode = 1'b0;
    cyc(2);
    wait_pre(SD - 1);
    mode = 1'b1;
    cyc(2);
    // mid-run reset
    wait_pos(6);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(10);
    repeat (500) begin
      en  = ($urandom_range(0, 7) != 0);
      dir = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      rst = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 1 && sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_ring_chaser.md
Name: seg_ring_chaser

Overview:
- Parametrised successor to the two-direction rotating-square display driver.
- Animates a pattern around an N-digit multiplexed seven-segment display, with programmable step rate and scan rate.
- Two modes: circulating square, and perimeter snake (a single segment tracing the display outline).
- Sits between board switches/buttons and the anode/segment pins. Outputs are active-low and registered.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes; minimum 2.
- STEP_DIV, 50_000_000, clk cycles per animation step; minimum 1.
- SCAN_DIV, 100_000, clk cycles per digit refresh slot; minimum 1.

Ports:
- clk  in  1  system clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = animation advances; 0 = position frozen, scan continues.
- dir  in  1  1 = clockwise (position increments); 0 = counter-clockwise (position decrements).
- mode  in  1  0 = square, 1 = snake.
- an  out  NUM_DIGITS  active-low one-hot anode enables; an[0] = rightmost digit.
- sseg  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- pos  out  $clog2(2*NUM_DIGITS+4)  current animation position, for debug/verification.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at a clk edge) sets:
  - an = all ones, sseg = 8'hFF, pos = 0.
  - step prescaler = 0, scan counter = 0, digit index = 0, mode_q = mode.
- Step prescaler:
  - Counts 0..STEP_DIV-1 only while en=1; holds while en=0.
  - Emits a 1-cycle step tick on terminal count, then wraps to 0.
- Position ring length L:
  - Square mode: L = 2N.
  - Snake mode: L = 2N+4.
- On a step tick: pos = (pos+1) mod L if dir=1, else (pos-1) mod L. 0 decrements to L-1; L-1 increments to 0.
- dir is sampled on the tick cycle only.
- Mode change (mode != mode_q):
  - Next cycle: pos=0, prescaler=0, mode_q updated.
  - A mode change takes precedence over a simultaneous tick.
- Square mapping for position p (upper square = 8'h9C, lower square = 8'hA3):
  - p<N: upper square on digit N-1-p.
  - p>=N: lower square on digit p-N.
- Snake mapping for position p (segment codes: a=8'hFE, b=8'hFD, c=8'hFB, d=8'hF7, e=8'hEF, f=8'hDF):
  - p<N: a on digit N-1-p.
  - p=N: b on digit 0.
  - p=N+1: c on digit 0.
  - N+2..2N+1: d on digit p-(N+2).
  - p=2N+2: e on digit N-1.
  - p=2N+3: f on digit N-1.
- Scan:
  - The scan counter always runs, independent of en.
  - Every SCAN_DIV cycles, digit index advances 0..N-1 and wraps.
- Output registers, 1-cycle latency from digit index/pos:
  - an = ~(1 << digit).
  - sseg = pattern if digit == target digit, else 8'hFF.
  - dp is always 1.
- Reset asserted mid-animation returns all state to reset values on that edge; no partial step.
- Parameter bounds: out-of-range parameters are a compile-time error (elaboration assertion).

Decomposition:
- Package seg_ring_pkg holds:
  - sseg_t (logic [7:0]).
  - SEG_BLANK, SEG_UPPER_SQ, SEG_LOWER_SQ, SEG_A..SEG_F.
  - mode enum {MODE_SQUARE, MODE_SNAKE}.
  - function ring_len(mode, n).
- One sub-module: tick_gen (param DIV; ports clk, rst, en, tick), instantiated twice: step prescaler, and scan with en tied 1.
- The pos-to-(digit, pattern) mapping is a combinational function inside seg_ring_chaser.

Test Plan:
All scenarios use NUM_DIGITS=4, STEP_DIV=4, SCAN_DIV=1, clk period 4 ns.
1. Reset: rst=1 for 2 edges -> an=4'hF, sseg=8'hFF, pos=0. After release, an cycles 1110, 1101, 1011, 0111, one step per clk.
2. Clockwise square: en=1, dir=1, mode=0 -> pos steps every 4 cycles 0,1,…,7,0.
   - pos=0: digit 3 (an=0111) shows sseg=8'h9C; other slots 8'hFF.
   - pos=4: digit 0 (an=1110) shows 8'hA3.
3. Counter-clockwise wrap: dir=0 from pos=0 -> next tick pos=7, lower square on digit 3 (an=0111, sseg=8'hA3).
4. Freeze: en=0 for 20 cycles at pos=2 -> pos stays 2, prescaler holds, an keeps scanning. en=1 resumes with the remaining prescaler count.
5. Snake mode:
   - Switch mode 0->1 at pos=5 -> pos=0 next cycle.
   - cw stepping gives: pos 4 = digit 0 sseg 8'hFD; pos 5 = 8'hFB; pos 10 = digit 3 8'hEF; pos 11 = digit 3 8'hDF.
   - Wrap to pos 0 = digit 3 8'hFE.
   - A tick on the same cycle as the mode change is ignored.
6. Mid-run reset: rst=1 pulse at pos=6 -> next edge pos=0, an=4'hF, sseg=8'hFF. Animation restarts from pos 0 four cycles after release.
